// File: rtl/salsa20_core_iter.sv
// Iterative Salsa20 core: ROUNDS total rounds, UNROLL double rounds per clock,
// optional feed-forward of the input state, start/busy/done handshake.
module salsa20_core_iter #(
    parameter int unsigned ROUNDS = 20,
    parameter int unsigned UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         feedforward,
    input  logic [511:0] in_state,
    output logic         busy,
    output logic         done,
    output logic [511:0] out_state
);
    localparam int unsigned N  = ROUNDS / (2 * UNROLL);
    localparam int unsigned CW = $clog2(N + 1);

    generate
        if (ROUNDS < 2 || (ROUNDS % 2) != 0 || UNROLL < 1 || ((ROUNDS / 2) % UNROLL) != 0) begin : g_param_check
            $error("salsa20_core_iter: ROUNDS must be even and >= 2, UNROLL must divide ROUNDS/2");
        end
    endgenerate

    // Word i of the packed state lives in element 15-i, so word 0 sits in the MSBs.
    typedef logic [15:0][31:0] state_t;
    typedef enum logic [1:0] {IDLE, RUN, FINAL} fsm_t;

    fsm_t          state, state_nx;
    state_t        x, orig, x_step, result;
    logic          ff;
    logic [CW-1:0] cnt;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned r);
        return (v << r) | (v >> (32 - r));
    endfunction

    // a, b, c, d are word numbers (y0..y3 of the group).
    function automatic state_t quarter(input state_t s, input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        state_t t;
        t = s;
        t[4'd15 - b] = t[4'd15 - b] ^ rotl(t[4'd15 - a] + t[4'd15 - d], 7);
        t[4'd15 - c] = t[4'd15 - c] ^ rotl(t[4'd15 - b] + t[4'd15 - a], 9);
        t[4'd15 - d] = t[4'd15 - d] ^ rotl(t[4'd15 - c] + t[4'd15 - b], 13);
        t[4'd15 - a] = t[4'd15 - a] ^ rotl(t[4'd15 - d] + t[4'd15 - c], 18);
        return t;
    endfunction

    function automatic state_t double_round(input state_t s);
        state_t t;
        t = quarter(s, 4'd0,  4'd4,  4'd8,  4'd12);
        t = quarter(t, 4'd5,  4'd9,  4'd13, 4'd1);
        t = quarter(t, 4'd10, 4'd14, 4'd2,  4'd6);
        t = quarter(t, 4'd15, 4'd3,  4'd7,  4'd11);
        t = quarter(t, 4'd0,  4'd1,  4'd2,  4'd3);
        t = quarter(t, 4'd5,  4'd6,  4'd7,  4'd4);
        t = quarter(t, 4'd10, 4'd11, 4'd8,  4'd9);
        t = quarter(t, 4'd15, 4'd12, 4'd13, 4'd14);
        return t;
    endfunction

    always_comb begin
        x_step = x;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            x_step = double_round(x_step);
        end
    end

    always_comb begin
        result = x;
        if (ff) begin
            for (int unsigned i = 0; i < 16; i++) begin
                result[i] = x[i] + orig[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = RUN;
            end
            RUN:     if (cnt == CW'(N - 1)) state_nx = FINAL;
            FINAL:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            orig      <= '0;
            ff        <= 1'b0;
            cnt       <= '0;
            out_state <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x    <= in_state;
                    orig <= in_state;
                    ff   <= feedforward;
                    cnt  <= '0;
                end
                RUN: begin
                    x   <= x_step;
                    cnt <= cnt + 1'b1;
                end
                FINAL: begin
                    out_state <= result;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_salsa20_core_iter.sv
// Scoreboard bench for salsa20_core_iter: four instances with different ROUNDS/UNROLL
// share stimulus; expected results are queued at launch and checked on done.
module tb_salsa20_core_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   st;
    logic         ff;
    logic [511:0] din;
    logic [511:0] os [4];
    logic         dn [4];
    logic         bz [4];

    typedef struct {
        logic [511:0] val;
        int           due;
    } exp_t;

    exp_t         expq [4][$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           busycnt [4];
    logic [511:0] last_os [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    salsa20_core_iter #(.ROUNDS(20), .UNROLL(1)) u_r20u1 (
        .clk(clk), .rst(rst), .start(st[0]), .feedforward(ff), .in_state(din),
        .busy(bz[0]), .done(dn[0]), .out_state(os[0]));
    salsa20_core_iter #(.ROUNDS(20), .UNROLL(2)) u_r20u2 (
        .clk(clk), .rst(rst), .start(st[1]), .feedforward(ff), .in_state(din),
        .busy(bz[1]), .done(dn[1]), .out_state(os[1]));
    salsa20_core_iter #(.ROUNDS(20), .UNROLL(5)) u_r20u5 (
        .clk(clk), .rst(rst), .start(st[2]), .feedforward(ff), .in_state(din),
        .busy(bz[2]), .done(dn[2]), .out_state(os[2]));
    salsa20_core_iter #(.ROUNDS(2), .UNROLL(1)) u_r2u1 (
        .clk(clk), .rst(rst), .start(st[3]), .feedforward(ff), .in_state(din),
        .busy(bz[3]), .done(dn[3]), .out_state(os[3]));

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        case (i)
            0:       return 11;
            1:       return 6;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] v, input int c);
        return (v << c) | (v >> (32 - c));
    endfunction

    // Reference Salsa20 core written in the classic word-array form.
    function automatic logic [511:0] salsa_ref(input logic [511:0] s, input int rounds, input logic f);
        logic [31:0]  x [16];
        logic [31:0]  o [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            x[i] = s[511 - 32*i -: 32];
            o[i] = x[i];
        end
        for (int n = 0; n < rounds; n += 2) begin
            x[4]  ^= rol(x[0]  + x[12], 7);  x[8]  ^= rol(x[4]  + x[0],  9);
            x[12] ^= rol(x[8]  + x[4],  13); x[0]  ^= rol(x[12] + x[8],  18);
            x[9]  ^= rol(x[5]  + x[1],  7);  x[13] ^= rol(x[9]  + x[5],  9);
            x[1]  ^= rol(x[13] + x[9],  13); x[5]  ^= rol(x[1]  + x[13], 18);
            x[14] ^= rol(x[10] + x[6],  7);  x[2]  ^= rol(x[14] + x[10], 9);
            x[6]  ^= rol(x[2]  + x[14], 13); x[10] ^= rol(x[6]  + x[2],  18);
            x[3]  ^= rol(x[15] + x[11], 7);  x[7]  ^= rol(x[3]  + x[15], 9);
            x[11] ^= rol(x[7]  + x[3],  13); x[15] ^= rol(x[11] + x[7],  18);
            x[1]  ^= rol(x[0]  + x[3],  7);  x[2]  ^= rol(x[1]  + x[0],  9);
            x[3]  ^= rol(x[2]  + x[1],  13); x[0]  ^= rol(x[3]  + x[2],  18);
            x[6]  ^= rol(x[5]  + x[4],  7);  x[7]  ^= rol(x[6]  + x[5],  9);
            x[4]  ^= rol(x[7]  + x[6],  13); x[5]  ^= rol(x[4]  + x[7],  18);
            x[11] ^= rol(x[10] + x[9],  7);  x[8]  ^= rol(x[11] + x[10], 9);
            x[9]  ^= rol(x[8]  + x[11], 13); x[10] ^= rol(x[9]  + x[8],  18);
            x[12] ^= rol(x[15] + x[14], 7);  x[13] ^= rol(x[12] + x[15], 9);
            x[14] ^= rol(x[13] + x[12], 13); x[15] ^= rol(x[14] + x[13], 18);
        end
        for (int i = 0; i < 16; i++) begin
            r[511 - 32*i -: 32] = f ? x[i] + o[i] : x[i];
        end
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < 4; i++) t += expq[i].size();
        return t;
    endfunction

    task automatic push_exp(input int i, input logic [511:0] e, input int due);
        exp_t t;
        t.val = e;
        t.due = due;
        expq[i].push_back(t);
    endtask

    // Called on a falling edge; start is sampled at the following rising edge.
    task automatic launch(input logic [3:0] mask, input logic [511:0] s, input logic f, input logic [511:0] e);
        din = s;
        ff  = f;
        for (int i = 0; i < 4; i++) if (mask[i]) push_exp(i, e, cyc + 1 + lat_of(i));
        st = mask;
        @(negedge clk);
        st = '0;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (pending() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 512'(pending()), '0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                busycnt[i] = 0;
            end else begin
                if (bz[i]) busycnt[i]++;
                if (!dn[i] && os[i] !== last_os[i])
                    check_eq($sformatf("out_hold%0d", i), os[i], last_os[i]);
                if (dn[i]) begin
                    if (expq[i].size() == 0) begin
                        check_eq($sformatf("done_unexpected%0d", i), 512'(dn[i]), '0);
                    end else begin
                        e = expq[i].pop_front();
                        check_eq($sformatf("out%0d", i), os[i], e.val);
                        check_eq($sformatf("done_cycle%0d", i), 512'(cyc), 512'(e.due));
                        check_eq($sformatf("busy_len%0d", i), 512'(busycnt[i]), 512'(lat_of(i)));
                    end
                    busycnt[i] = 0;
                end
            end
            last_os[i] = os[i];
        end
    end

    initial begin
        logic [511:0] kat_in, kat_raw, kat_ff, ra, rb, rc;
        int c;
        kat_in  = 512'd1 << 480;
        kat_raw = {32'h8186a22d, 32'h0040a284, 32'h82479210, 32'h06929051,
                   32'h08000090, 32'h02402200, 32'h00004000, 32'h00800000,
                   32'h00010200, 32'h20400000, 32'h08008104, 32'h00000000,
                   32'h20500000, 32'ha0000040, 32'h0008180a, 32'h612a8020};
        kat_ff  = {32'h8186a22e, kat_raw[479:0]};
        st  = '0;
        ff  = 1'b0;
        din = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("rst_busy%0d", i), 512'(bz[i]), '0);
            check_eq($sformatf("rst_done%0d", i), 512'(dn[i]), '0);
            check_eq($sformatf("rst_out%0d", i), os[i], '0);
        end
        rst = 1'b0;
        @(negedge clk);

        launch(4'b0001, '0, 1'b1, '0);
        drain("drain_zero");

        launch(4'b1000, kat_in, 1'b0, kat_raw);
        drain("drain_kat_raw");
        launch(4'b1000, kat_in, 1'b1, kat_ff);
        drain("drain_kat_ff");

        // Same random state through three unroll factors; a start pulse mid-job is ignored.
        ra = rand512();
        launch(4'b0111, ra, 1'b1, salsa_ref(ra, 20, 1'b1));
        @(negedge clk);
        din = rand512();
        st  = 4'b0111;
        @(negedge clk);
        st  = '0;
        drain("drain_unroll_ff");
        rb = rand512();
        launch(4'b0111, rb, 1'b0, salsa_ref(rb, 20, 1'b0));
        drain("drain_unroll_raw");

        // start held high: second job accepted in the done cycle.
        ra = rand512();
        rb = rand512();
        c  = cyc;
        push_exp(0, salsa_ref(ra, 20, 1'b1), c + 12);
        push_exp(0, salsa_ref(rb, 20, 1'b1), c + 24);
        din   = ra;
        ff    = 1'b1;
        st[0] = 1'b1;
        @(negedge clk);
        din = rb;
        while (cyc < c + 13 && cyc < c + 100) @(negedge clk);
        st[0] = 1'b0;
        drain("drain_held_start");

        // Asynchronous reset mid-RUN discards the job.
        rc = rand512();
        launch(4'b0001, rc, 1'b1, salsa_ref(rc, 20, 1'b1));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        expq[0].delete();
        check_eq("midrst_busy", 512'(bz[0]), '0);
        check_eq("midrst_done", 512'(dn[0]), '0);
        check_eq("midrst_out", os[0], '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("post_rst_out", os[0], '0);
        rc = rand512();
        launch(4'b0001, rc, 1'b0, salsa_ref(rc, 20, 1'b0));
        drain("drain_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/salsa20_core_iter.md
Name: salsa20_core_iter

Overview:
- Iterative, parametrised Salsa20 core operating on the 16-word, 512-bit state.
- Successor to the single-cycle double-round datapath. Generalised in three ways:
  - round count and unroll factor are parameters;
  - feed-forward addition is selectable per job;
  - a start/busy/done handshake is added.
- Sits between the keystream controller (which builds the state) and the XOR/output stage.

Parameters:
- ROUNDS, 20: total Salsa rounds. Legal values 8, 12, 20 (any even value >= 2).
- UNROLL, 1: double rounds computed per clock. UNROLL must divide ROUNDS/2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request. Sampled only while idle.
- feedforward  in  1  1 = output is rounds result + input state (Salsa20 core); 0 = raw rounds result. Latched with start.
- in_state  in  512  input state. Word i occupies bits [511-32i : 480-32i], so word 0 is in the MSBs.
- busy  out  1  high while a job is in progress.
- done  out  1  one-cycle pulse when out_state is updated.
- out_state  out  512  result, same word packing as in_state. Held until the next done.

Behaviour:
- Reset (asynchronous, any time, including mid-job):
  - state goes to IDLE; busy=0, done=0, out_state=0;
  - internal registers are cleared; any in-flight job is discarded and produces no done.
- Definition: N = ROUNDS/(2*UNROLL) iteration cycles.
- FSM: IDLE, RUN, FINAL.
  - IDLE: busy=0.
    - If start=1 at a clock edge: latch in_state into working register x and into copy orig; latch feedforward; clear counter; go to RUN.
    - If start=0, remain in IDLE.
  - RUN: busy=1.
    - Each edge: x <= UNROLL successive double rounds applied to x; counter increments.
    - After the N-th RUN edge, go to FINAL.
  - FINAL: busy=1.
    - On the edge: out_state <= ff ? (x + orig per word, mod 2^32) : x; done <= 1 for one cycle; go to IDLE.
- Timing: start sampled at edge k. busy rises after edge k. out_state and done update after edge k+N+1, and busy falls after the same edge. Latency is N+1 cycles, so ROUNDS=20, UNROLL=1 gives 11.
- Handshake corner cases:
  - start while busy: ignored. No queuing, no error.
  - start high in the cycle where done=1: accepted, because the FSM is already in IDLE. This gives back-to-back throughput of one job per N+1 cycles.
  - in_state and feedforward may change freely after the start edge.
- Double round = column round followed by row round. Each quarter-round step is b ^= (a+c) <<< r, 32-bit add with wraparound, rotate left.
  - Column round. Word order per group (a group of 4 words y0..y3): y1^=(y0+y3)<<<7, y2^=(y1+y0)<<<9, y3^=(y2+y1)<<<13, y0^=(y3+y2)<<<18. Groups: (0,4,8,12), (5,9,13,1), (10,14,2,6), (15,3,7,11).
  - Row round: same operation on groups (0,1,2,3), (5,6,7,4), (10,11,8,9), (15,12,13,14).
- Arithmetic: all adds are 32-bit, modulo 2^32, with no carry between words. No byte swapping inside the core; the word values are used as given.
- out_state is unchanged between done pulses, including while busy.
- ROUNDS and UNROLL are elaboration-time checks; illegal combinations must stop elaboration. The counter is sized to ceil(log2(N+1)) bits.

Test Plan:
- All-zero in_state, ROUNDS=20, feedforward=1, pulse start → done exactly 11 cycles later; out_state=0; busy high for exactly 11 cycles.
- ROUNDS=2, feedforward=0, in_state word0=0x00000001, all other words 0 → out_state words 0..15 = 8186a22d 0040a284 82479210 06929051 08000090 02402200 00004000 00800000 00010200 20400000 08008104 00000000 20500000 a0000040 0008180a 612a8020.
- Same stimulus with feedforward=1 → word0=0x8186a22e; all other words equal the previous case.
- ROUNDS=20 with UNROLL=1, 2 and 5 on an identical random state with feedforward=1 → identical out_state matching the software Salsa20 model; done latency is 11, 6 and 3 cycles respectively.
- start held high continuously across two jobs → second job accepted on the done cycle; done pulses spaced N+1 cycles apart; start pulses issued while busy produce no extra done.
- rst asserted asynchronously mid-RUN (between edges) → busy, done and out_state are 0 immediately; no done follows. A fresh start after rst is released completes normally with the correct result.
